// File: rtl/alu_shift_pkg.sv
// Shared encodings for the iterative shift/rotate unit.
package alu_shift_pkg;

  typedef enum logic [2:0] {
    OP_SHL  = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHRA = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= 3'(OP_ROR));
  endfunction

endpackage

// File: rtl/alu_shift_unit_shift_step.sv
// Combinational one-step shifter: moves value by k (0..STEP) positions and
// reports the last bit pushed off the active end.
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       op,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] shifted,
  output logic             out_bit
);

  logic [31:0]      k_n;
  logic [31:0]      k_l;
  logic [31:0]      k_r;
  logic [WIDTH-1:0] msb_src;
  logic [WIDTH-1:0] lsb_src;

  always_comb begin
    k_n = 32'(k);
    k_l = 32'(WIDTH) - k_n;
    k_r = (k_n == 32'd0) ? 32'd0 : k_n - 32'd1;
    // bit 0 of these holds the last bit to leave the MSB / LSB end
    msb_src = value >> k_l;
    lsb_src = value >> k_r;
    shifted = value;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        shifted = value << k_n;
        out_bit = (k_n != 32'd0) & msb_src[0];
      end
      OP_SHR: begin
        shifted = value >> k_n;
        out_bit = (k_n != 32'd0) & lsb_src[0];
      end
      OP_SHRA: begin
        shifted = WIDTH'($signed(value) >>> k_n);
        out_bit = (k_n != 32'd0) & lsb_src[0];
      end
      OP_ROL: begin
        shifted = (value << k_n) | (value >> k_l);
        out_bit = (k_n != 32'd0) & msb_src[0];
      end
      OP_ROR: begin
        shifted = (value >> k_n) | (value << k_l);
        out_bit = (k_n != 32'd0) & lsb_src[0];
      end
      default: begin
        shifted = value;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_shift_unit.sv
// Multi-cycle shift/rotate unit: up to STEP positions per clock, registered
// result and flags, one-cycle done pulse.
//   state   | meaning
//   ST_IDLE | waiting for start; outputs hold last completed result
//   ST_RUN  | shifting working register until remaining count hits 0
module alu_shift_unit
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         A,
  input  logic [$clog2(WIDTH)-1:0] amt,
  output logic [WIDTH-1:0]         result,
  output logic                     carry,
  output logic                     zero,
  output logic                     err,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(WIDTH);
  localparam int KW = $clog2(STEP + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             cout_q, cout_d;
  logic             ill_q, ill_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic             done_q, done_d;

  logic [KW-1:0]    step_k;
  logic [WIDTH-1:0] step_val;
  logic             step_out;

  assign step_k = (cnt_q >= AW'(STEP)) ? KW'(STEP) : KW'(cnt_q);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .KW    (KW)
  ) u_step (
    .value   (work_q),
    .op      (op_q),
    .k       (step_k),
    .shifted (step_val),
    .out_bit (step_out)
  );

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    cout_d   = cout_q;
    ill_d    = ill_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          work_d  = A;
          op_d    = op;
          cout_d  = 1'b0;
          ill_d   = ~op_is_legal(op);
          // illegal ops skip shifting so they finish with amt=0 latency
          cnt_d   = op_is_legal(op) ? amt : '0;
        end
      end
      ST_RUN: begin
        if (cnt_q != '0) begin
          work_d = step_val;
          cnt_d  = cnt_q - AW'(step_k);
          cout_d = step_out;
        end else begin
          result_d = work_q;
          carry_d  = cout_q;
          zero_d   = (work_q == '0);
          err_d    = ill_q;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      cout_q   <= 1'b0;
      ill_q    <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      cout_q   <= cout_d;
      ill_q    <= ill_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign err    = err_q;
  assign done   = done_q;
  assign busy   = (state_q == ST_RUN);

endmodule

// File: tb/tb_alu_shift_unit.sv
// Randomized and directed bench for alu_shift_unit (STEP=1 and STEP=4 instances)
// against a bit-at-a-time reference model.
module tb_alu_shift_unit;

  logic        clock = 1'b0;
  logic        clear;
  logic        start1, start4;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [4:0]  amt_i;

  logic [31:0] res1, res4;
  logic        carry1, carry4, zero1, zero4, err1, err4, busy1, busy4, done1, done4;

  int checks = 0;
  int failures = 0;
  bit sel = 1'b0;

  logic [31:0] rs;
  logic        cs, zs, es, bs, ds;
  assign rs = sel ? res4   : res1;
  assign cs = sel ? carry4 : carry1;
  assign zs = sel ? zero4  : zero1;
  assign es = sel ? err4   : err1;
  assign bs = sel ? busy4  : busy1;
  assign ds = sel ? done4  : done1;

  always #5 clock = ~clock;

  alu_shift_unit #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clock(clock), .clear(clear), .start(start1), .op(op_i), .A(a_i), .amt(amt_i),
    .result(res1), .carry(carry1), .zero(zero1), .err(err1), .busy(busy1), .done(done1));

  alu_shift_unit #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clock(clock), .clear(clear), .start(start4), .op(op_i), .A(a_i), .amt(amt_i),
    .result(res4), .carry(carry4), .zero(zero4), .err(err4), .busy(busy4), .done(done4));

  // Reference: move one bit per iteration, remembering the bit that fell off.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input int n,
                                output logic [31:0] r, output logic c, output logic e);
    r = a; c = 1'b0; e = 1'b0;
    if (o > 3'd4) begin
      e = 1'b1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      case (o)
        3'd0: begin c = r[31]; r = {r[30:0], 1'b0}; end
        3'd1: begin c = r[0];  r = {1'b0, r[31:1]}; end
        3'd2: begin c = r[0];  r = {r[31], r[31:1]}; end
        3'd3: begin c = r[31]; r = {r[30:0], r[31]}; end
        default: begin c = r[0]; r = {r[0], r[31:1]}; end
      endcase
    end
  endfunction

  function automatic int exp_latency(input logic [2:0] o, input int n, input int step);
    if (o > 3'd4) return 1;
    return (n + step - 1) / step + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One complete operation on the selected instance, all outputs checked.
  task automatic run_op(input bit s, input logic [2:0] o, input logic [31:0] a,
                        input logic [4:0] n, input string tag);
    logic [31:0] er, prev;
    logic        ec, ee;
    int          lat, elat;
    bit          held;
    sel = s;
    #0;
    model(o, a, int'(n), er, ec, ee);
    elat = exp_latency(o, int'(n), s ? 4 : 1);
    prev = rs;
    op_i = o; a_i = a; amt_i = n;
    if (s) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clock); #1;
    start1 = 1'b0; start4 = 1'b0;
    chk({tag, " busy_after_start"}, 32'(bs), 32'd1);
    lat = 0; held = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clock); #1;
      if (ds) begin lat = i; break; end
      if (rs !== prev) held = 1'b0;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " hold_during_run"}, 32'(held), 32'd1);
    chk({tag, " result"}, rs, er);
    chk({tag, " carry"}, 32'(cs), 32'(ec));
    chk({tag, " zero"}, 32'(zs), 32'(er == 32'd0));
    chk({tag, " err"}, 32'(es), 32'(ee));
    @(posedge clock); #1;
    chk({tag, " done_one_cycle"}, 32'(ds), 32'd0);
    chk({tag, " idle_after"}, 32'(bs), 32'd0);
  endtask

  task automatic test_reset();
    clear = 1'b1; start1 = 1'b0; start4 = 1'b0;
    op_i = '0; a_i = '0; amt_i = '0;
    repeat (3) @(posedge clock);
    #1;
    clear = 1'b0;
    chk("reset result1", res1, 32'd0);
    chk("reset flags1", {27'd0, carry1, zero1, err1, busy1, done1}, 32'd0);
    chk("reset result4", res4, 32'd0);
    chk("reset flags4", {27'd0, carry4, zero4, err4, busy4, done4}, 32'd0);
  endtask

  task automatic test_directed();
    run_op(1'b0, 3'b100, 32'h0000_00F1, 5'd4,  "ror_f1");
    chk("ror_f1 value", res1, 32'h1000_000F);
    run_op(1'b0, 3'b010, 32'h8000_0000, 5'd31, "shra31_s1");
    run_op(1'b1, 3'b010, 32'h8000_0000, 5'd31, "shra31_s4");
    chk("shra31_s4 value", res4, 32'hFFFF_FFFF);
    run_op(1'b0, 3'b000, 32'hC000_0001, 5'd1,  "shl_c1");
    chk("shl_c1 value", res1, 32'h8000_0002);
    run_op(1'b0, 3'b011, 32'hC000_0001, 5'd1,  "rol_c1");
    chk("rol_c1 value", res1, 32'h8000_0003);
    run_op(1'b0, 3'b001, 32'h0000_0001, 5'd1,  "shr_zero");
    chk("shr_zero flag", 32'(zero1), 32'd1);
    run_op(1'b0, 3'b000, 32'h1234_5678, 5'd0,  "amt0");
    run_op(1'b0, 3'b111, 32'h1234_5678, 5'd0,  "illegal111");
    chk("illegal111 err", 32'(err1), 32'd1);
    run_op(1'b1, 3'b101, 32'hDEAD_BEEF, 5'd17, "illegal_s4");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 31)), "rand");
  endtask

  task automatic test_busy_ignore();
    logic [31:0] er; logic ec, ee; int lat;
    sel = 1'b0;
    model(3'b100, 32'hA5A5_0F0F, 10, er, ec, ee);
    op_i = 3'b100; a_i = 32'hA5A5_0F0F; amt_i = 5'd10; start1 = 1'b1;
    @(posedge clock); #1; start1 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3) begin op_i = 3'b000; a_i = 32'h0000_0001; amt_i = 5'd2; start1 = 1'b1; end
      @(posedge clock); #1;
      start1 = 1'b0;
      if (done1) begin lat = i; break; end
    end
    chk("ignore latency", 32'(lat), 32'd11);
    chk("ignore result", res1, er);
    chk("ignore carry", 32'(carry1), 32'(ec));
    @(posedge clock); #1;
  endtask

  task automatic test_clear_abort();
    bit saw;
    sel = 1'b0;
    saw = 1'b0;
    op_i = 3'b100; a_i = 32'h0F0F_1234; amt_i = 5'd10; start1 = 1'b1;
    @(posedge clock); #1; start1 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) start1 = 1'b1;
      if (i == 5) clear = 1'b1;
      @(posedge clock); #1;
      start1 = 1'b0;
      saw |= done1;
    end
    clear = 1'b0;
    chk("abort result", res1, 32'd0);
    chk("abort flags", {27'd0, carry1, zero1, err1, busy1, done1}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      @(posedge clock); #1;
      saw |= done1;
    end
    chk("abort no_done", 32'(saw), 32'd0);
    run_op(1'b0, 3'b011, 32'h8000_0001, 5'd3, "after_clear");
  endtask

  task automatic test_back_to_back();
    logic [31:0] e1, e2; logic c1, c2, x1, x2;
    int lat; bit held;
    sel = 1'b0;
    model(3'b000, 32'h0000_00FF, 3, e1, c1, x1);
    model(3'b100, 32'h0000_0013, 5, e2, c2, x2);
    op_i = 3'b000; a_i = 32'h0000_00FF; amt_i = 5'd3; start1 = 1'b1;
    @(posedge clock); #1; start1 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (done1) begin lat = i; break; end
    end
    chk("b2b first latency", 32'(lat), 32'd4);
    chk("b2b first result", res1, e1);
    op_i = 3'b100; a_i = 32'h0000_0013; amt_i = 5'd5; start1 = 1'b1;
    @(posedge clock); #1; start1 = 1'b0;
    chk("b2b no_bubble busy", 32'(busy1), 32'd1);
    lat = 0; held = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      if (done1) begin lat = i; break; end
      if (res1 !== e1) held = 1'b0;
    end
    chk("b2b first held", 32'(held), 32'd1);
    chk("b2b second latency", 32'(lat), 32'd6);
    chk("b2b second result", res1, e2);
    chk("b2b second carry", 32'(carry1), 32'(c2));
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_clear_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_shift_unit.md
ALU_SHIFT_UNIT -- requirements
Module: alu_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (power of two, >= 8).
REQ-002 SHALL have parameter STEP, default 1, maximum bit positions shifted per cycle (power of two, 1..WIDTH/2).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clear  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only while idle.
REQ-006 SHALL have port op  input  3  mode: 000 SHL, 001 SHR, 010 SHRA, 011 ROL, 100 ROR, 101..111 illegal.
REQ-007 SHALL have port A  input  WIDTH  operand.
REQ-008 SHALL have port amt  input  log2(WIDTH)  shift/rotate count; only the low log2(WIDTH) bits of any wider source are used.
REQ-009 SHALL have port result  output  WIDTH  registered result.
REQ-010 SHALL have port carry  output  1  last bit shifted or rotated out.
REQ-011 SHALL have port zero  output  1  result == 0.
REQ-012 SHALL have port err  output  1  illegal op flag for the completed operation.
REQ-013 SHALL have port busy  output  1  operation in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE and RUN; IDLE -> RUN on start; RUN -> IDLE when the remaining count is 0.
REQ-016 On the edge sampling start=1 in IDLE (edge 0), SHALL latch A, op and amt into a working register and a remaining-count register, and set busy=1.
REQ-017 In RUN with remaining count > 0, each edge SHALL shift the working register by min(remaining, STEP) and decrement the count by that amount.
REQ-018 In RUN with remaining count = 0, the edge SHALL load result, carry, zero and err, pulse done=1 for exactly one cycle, clear busy, and return to IDLE.
REQ-019 Latency: done is high in the cycle after edge N+1, where N = ceil(amt/STEP); amt=0 gives done after edge 1.
REQ-020 SHL and SHR SHALL zero-fill; SHRA SHALL replicate the sign bit of A; ROL and ROR SHALL wrap the bits around.
REQ-021 carry SHALL equal the final bit to leave its end (MSB side for SHL/ROL, LSB side for SHR/SHRA/ROR); carry SHALL be 0 when amt=0.
REQ-022 Illegal op SHALL give result=A, carry=0, err=1, with the same latency as amt=0.
REQ-023 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-024 start asserted in the done cycle SHALL be accepted (back-to-back operation, no bubble).
REQ-025 result, carry, zero and err SHALL hold their values until the next completion; they SHALL NOT change during RUN.

Reset
REQ-026 clear=1 SHALL force IDLE and result=0, carry=0, zero=0, err=0, busy=0, done=0, and clear the working and count registers.
REQ-027 clear asserted mid-operation SHALL abort the operation with no done pulse; clear SHALL take priority over start.

Structure
REQ-028 Op encodings and FSM state encodings SHALL reside in shared package alu_shift_pkg.
REQ-029 The one-step shifter SHALL be combinational sub-module shift_step: inputs value, op, k (0..STEP); outputs shifted value and out-bit.

Verification
REQ-030 (WIDTH=32, STEP=1) ROR A=0x000000F1, amt=4 -> result=0x1000000F, carry=0, done after edge 5.
REQ-031 (STEP=1) SHRA A=0x80000000, amt=31 -> result=0xFFFFFFFF, carry=0, done after edge 32; with STEP=4, done after edge 9.
REQ-032 SHL A=0xC0000001, amt=1 -> result=0x80000002, carry=1, zero=0; ROL with the same operands -> result=0x80000003, carry=1.
REQ-033 SHR A=0x00000001, amt=1 -> result=0, zero=1, carry=1; amt=0 and op=111 -> result=A, done after edge 1, and err=1 only for op=111.
REQ-034 start pulsed at edge 3 of an amt=10 ROR is ignored; clear at edge 5 of the same run -> no done pulse, all outputs 0, next start accepted normally.
REQ-035 Second start held high during the done cycle -> second operation accepted with no idle cycle, and the first result is held until the second done.
